// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, types and helpers for the rr_mux8to1 block.
//   N_CH     - number of source channels (8)
//   SEL_W    - width of a channel index (3)
//   sel_t    - channel index type
//   next_ptr - advance a round-robin pointer, wrapping 7 -> 0
package rr_mux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t next_ptr(input sel_t s);
        return (s == sel_t'(N_CH-1)) ? sel_t'(0) : s + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational circular search over an 8-bit request vector.
//   req   in  8 : request bits
//   start in  3 : index where the search begins (ascending, wraps 7 -> 0)
//   found out 1 : at least one request bit is set
//   idx   out 3 : first set index at or after start (0 when nothing found)
module rr_pick8
    import rr_mux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  sel_t            start,
    output logic            found,
    output sel_t            idx
);

    sel_t cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_CH; i++) begin
            // 3-bit addition wraps naturally past channel 7.
            cand = start + sel_t'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux8to1.sv
// rr_mux8to1: round-robin 8-to-1 valid/ready multiplexer with a registered
// output word tagged by its source channel index.
//
// Build option: RR_MUX_FIXED_PRIO_EN - when defined the round-robin pointer
// is removed and the lowest valid channel always wins.
//
// Ports:
//   clk       in  1          : clock, rising edge
//   rst       in  1          : asynchronous active-high reset
//   en        in  1          : allow new grants (held word still drains)
//   in_valid  in  8          : per-channel valid
//   in_data   in  8*DATA_W   : channel k at [k*DATA_W +: DATA_W]
//   in_ready  out 8          : per-channel accept, one-hot or zero
//   out_valid out 1          : output word valid
//   out_ready in  1          : downstream accept
//   out_data  out DATA_W     : registered data of the granted channel
//   out_sel   out 3          : registered index of the granted channel
module rr_mux8to1 #(
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [7:0]                   in_valid,
    input  logic [8*DATA_W-1:0]          in_data,
    output logic [7:0]                   in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [2:0]                   out_sel
);

    import rr_mux_pkg::*;

    logic slot_free;
    logic grant;
    logic found;
    sel_t pick_idx;
    sel_t start;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign start = '0;
`else
    sel_t ptr;
    assign start = ptr;
`endif

    rr_pick8 u_pick (
        .req   (in_valid),
        .start (start),
        .found (found),
        .idx   (pick_idx)
    );

    // Slot can be refilled in the same cycle it drains.
    assign slot_free = !out_valid || out_ready;
    // rst gating keeps in_ready low for the whole reset pulse, not just after the edge.
    assign grant     = !rst && en && slot_free && found;

    always_comb begin
        in_ready = '0;
        if (grant)
            in_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= in_data[pick_idx*DATA_W +: DATA_W];
            out_sel   <= pick_idx;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

`ifndef RR_MUX_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (grant)
            ptr <= next_ptr(pick_idx);
    end
`endif

endmodule

// File: tb/tb_rr_mux8to1.sv
module tb_rr_mux8to1;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] iv;
        logic       en;
        logic       ordy;
        logic [7:0] exp_irdy;
        logic       exp_ov;
        logic [2:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    rr_mux8to1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] iv, input logic e, input logic r,
                                input logic [7:0] irdy, input logic ov, input logic [2:0] sel);
        vec_t v;
        v.iv = iv; v.en = e; v.ordy = r;
        v.exp_irdy = irdy; v.exp_ov = ov; v.exp_sel = sel;
        v.exp_data = 8'hA0 + {5'd0, sel};
        return v;
    endfunction

    initial begin
        // Channel k always presents A0+k, so data and index can be cross-checked.
        for (int k = 0; k < 8; k++)
            in_data[k*DATA_W +: DATA_W] = 8'hA0 + 8'(k);
        rst = 1'b1; en = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;

`ifdef RR_MUX_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) tbl.push_back(mk(8'h06, 1, 1, 8'h02, 1, 3'd1));
        tbl.push_back(mk(8'h84, 1, 1, 8'h04, 1, 3'd2));
        tbl.push_back(mk(8'h80, 1, 1, 8'h80, 1, 3'd7));
        tbl.push_back(mk(8'h06, 1, 1, 8'h02, 1, 3'd1));
`else
        // Full sweep 0..7 then wrap to 0.
        for (int i = 0; i < 8; i++) tbl.push_back(mk(8'hFF, 1, 1, 8'h01 << i, 1, 3'(i)));
        tbl.push_back(mk(8'hFF, 1, 1, 8'h01, 1, 3'd0));
        // ptr=1 with only ch7/ch0: ch7 then ch0.
        tbl.push_back(mk(8'h81, 1, 1, 8'h80, 1, 3'd7));
        tbl.push_back(mk(8'h81, 1, 1, 8'h01, 1, 3'd0));
        // Backpressure for 5 cycles: word held, nothing accepted.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(8'hFF, 1, 0, 8'h00, 1, 3'd0));
        // Drain with no valid inputs: slot empties.
        tbl.push_back(mk(8'h00, 1, 1, 8'h00, 0, 3'd0));
        // ptr=1, only ch2 valid, slot empty so grant despite out_ready=0.
        tbl.push_back(mk(8'h04, 1, 0, 8'h04, 1, 3'd2));
        // en low while held: hold, drain, stay empty.
        tbl.push_back(mk(8'hFF, 0, 0, 8'h00, 1, 3'd2));
        tbl.push_back(mk(8'hFF, 0, 1, 8'h00, 0, 3'd2));
        tbl.push_back(mk(8'hFF, 0, 1, 8'h00, 0, 3'd2));
        // Re-enable: resumes at ptr=3.
        tbl.push_back(mk(8'hFF, 1, 1, 8'h08, 1, 3'd3));
        tbl.push_back(mk(8'hFF, 1, 1, 8'h10, 1, 3'd4));
`endif

        // Reset state while inputs are all asserted.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            in_valid  = tbl[i].iv;
            en        = tbl[i].en;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_irdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(tbl[i].exp_sel));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
        end

        // Async reset mid-stream, not aligned to either clock edge.
        @(negedge clk);
        in_valid = 8'hFF; en = 1'b1; out_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd0);
        chk("async_rst_out_sel",   32'(out_sel),   32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        in_valid = 8'h24;
        #1;
        // ptr is back at 0, so ch2 (lowest valid) wins rather than ch5.
        chk("post_rst_in_ready", 32'(in_ready), 32'h04);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_sel",   32'(out_sel),   32'd2);
        chk("post_rst_out_data",  32'(out_data),  32'hA2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
